program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Replaces the free-running program counter with a controlled instruction sequencer for the 8-bit accumulator core.
- Drives the program memory address and gates every datapath write (accumulator, carry, register file, data memory) through a single execute-enable.
- Adds jump, conditional branch on carry/zero, call/return via a small hardware return stack, halt/resume, and a debug single-step mode.

Parameters:
ADDR_W, 6, program memory address width; the PC wraps at 2^ADDR_W-1 to 0
STACK_DEPTH, 4, number of return-stack entries (power of 2)

Ports:
clk  in  1  system clock, rising-edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  one-cycle pulse; leaves IDLE or resumes from HALT
DbgMode  in  1  1 = single-step mode
Step  in  1  one-cycle pulse; executes one instruction while DbgMode=1
Jump  in  1  decoded unconditional jump
BrC  in  1  decoded branch-if-carry
BrZ  in  1  decoded branch-if-accumulator-zero
Call  in  1  decoded call
Ret  in  1  decoded return
HaltIns  in  1  decoded halt
Target  in  ADDR_W  jump/branch/call destination from the instruction
CarryFlag  in  1  current carry register output
AccuZero  in  1  1 when accumulator == 0
Addr  out  ADDR_W  program memory address (registered PC)
ExecEn  out  1  ANDed into every datapath CE/WE
Halted  out  1  1 in HALT
Fault  out  1  1 in FAULT
StepAck  out  1  one-cycle pulse after a stepped instruction completes

Behaviour:
- Reset (async, asserted high) drives: state IDLE, Addr=0, stack pointer=0, all stack entries=0, ExecEn=0, Halted=0, Fault=0, StepAck=0. Reset asserted mid-instruction aborts that instruction; no datapath write occurs because ExecEn drops combinationally.
- States (enum):
  - IDLE: Start -> RUN.
  - RUN: executes one instruction per cycle.
  - STEPWAIT: in debug mode, waits for Step.
  - HALT: reached by a halt instruction.
  - FAULT: sticky; exits only on Reset.
- ExecEn is combinational. It equals 1 in RUN when DbgMode=0, or in STEPWAIT when Step=1, and HaltIns=0. In every other case ExecEn=0.
- Next-PC, applied at the clock edge only when the instruction is "executing" (the ExecEn condition ignoring HaltIns). Priority order:
  1. Ret: pop the stack; PC = popped value.
  2. Call: push PC+1; PC = Target.
  3. Jump: PC = Target.
  4. BrC & CarryFlag, or BrZ & AccuZero: PC = Target.
  5. HaltIns: PC holds; go to HALT.
  6. Otherwise: PC = PC+1, modulo 2^ADDR_W (63 -> 0).
- Multiple decoder strobes in one cycle: the highest-priority strobe wins; lower-priority strobes are ignored with no side effects.
- Return stack:
  - Push to a full stack (pointer == STACK_DEPTH) -> FAULT; PC and stack are unchanged.
  - Pop from an empty stack -> FAULT; PC is unchanged.
  - Push and pop never occur in the same cycle, because of the priority order.
- HALT: Halted=1, Addr holds the halt address. Start -> PC+1, then RUN (or STEPWAIT if DbgMode=1).
- Debug mode:
  - RUN with DbgMode=1 -> STEPWAIT at the next edge, with no instruction executed in that cycle.
  - STEPWAIT with Step: execute one instruction; StepAck=1 in the following cycle.
  - STEPWAIT with DbgMode=0 -> RUN.
  - A Step pulse arriving outside STEPWAIT is ignored.
- FAULT: ExecEn=0, Fault=1, Addr holds.
- Outputs Halted, Fault and StepAck are registered. Addr changes exactly one cycle after the executed instruction.

Decomposition:
- Package uproc_seq_pkg: seq_state_t enum {IDLE, RUN, STEPWAIT, HALT, FAULT}, plus ADDR_W and STACK_DEPTH defaults.
- Sub-module return_stack: LIFO with push/pop, full/empty outputs, and async active-high reset. Its ports are clk, Reset, Push, Pop, DIn, DOut, Full, Empty.

Test Plan:
1. Reset, then Start, with no branch strobes for 70 cycles -> Addr sequence 0, 1, ..., 63, 0, ..., 5; ExecEn=1 throughout RUN.
2. Reset asserted while at Addr=0x12 in RUN -> Addr=0, state IDLE and ExecEn=0 in the same cycle; Start required to run again.
3. At Addr=5: Call Target=0x20 -> Addr=0x20. At 0x22: Ret -> Addr=6. Five nested Calls -> fifth Call gives Fault=1 and Addr unchanged. Ret with empty stack after reset -> Fault=1.
4. BrC with CarryFlag=0 at 8 -> Addr=9. BrC with CarryFlag=1, Target=0x30 -> Addr=0x30. Jump+BrZ+Call together with AccuZero=1 -> Call wins and the stack pointer increments.
5. HaltIns at 0x0A -> Halted=1, ExecEn=0, Addr holds 0x0A for 10 cycles. Start -> Addr=0x0B, Halted=0.
6. DbgMode=1 in RUN -> STEPWAIT, Addr holds. Three Step pulses spaced 4 cycles apart -> Addr advances by exactly 3, with one StepAck per step. A Step pulse in HALT -> ignored.

Source files
------------

// File: rtl/uproc_seq_pkg.sv
// Shared types and default sizes for the accumulator-core instruction sequencer.
package uproc_seq_pkg;

    localparam int DEF_ADDR_W      = 6;
    localparam int DEF_STACK_DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEPWAIT,
        HALT,
        FAULT
    } seq_state_t;

endpackage

// File: rtl/program_sequencer_return_stack.sv
// Small hardware LIFO holding call return addresses.
module return_stack #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         Push,
    input  logic         Pop,
    input  logic [W-1:0] DIn,
    output logic [W-1:0] DOut,
    output logic         Full,
    output logic         Empty
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] sp;
    logic [PW-1:0] sp_dec;

    assign sp_dec = sp - PW'(1);
    assign DOut   = mem[sp_dec[IW-1:0]];
    assign Full   = (sp == PW'(DEPTH));
    assign Empty  = (sp == '0);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (Push && !Full) begin
            mem[sp[IW-1:0]] <= DIn;
            sp              <= sp + PW'(1);
        end else if (Pop && !Empty) begin
            sp <= sp_dec;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Controlled PC sequencer: jump/branch/call/return, halt/resume and single-step.
module program_sequencer
    import uproc_seq_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              DbgMode,
    input  logic              Step,
    input  logic              Jump,
    input  logic              BrC,
    input  logic              BrZ,
    input  logic              Call,
    input  logic              Ret,
    input  logic              HaltIns,
    input  logic [ADDR_W-1:0] Target,
    input  logic              CarryFlag,
    input  logic              AccuZero,
    output logic [ADDR_W-1:0] Addr,
    output logic              ExecEn,
    output logic              Halted,
    output logic              Fault,
    output logic              StepAck
);

    seq_state_t        state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, pc_inc, top;
    logic              go, push, pop, ack_n;
    logic              full, empty;

    return_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .Reset (Reset),
        .Push  (push),
        .Pop   (pop),
        .DIn   (pc_inc),
        .DOut  (top),
        .Full  (full),
        .Empty (empty)
    );

    assign pc_inc = pc + ADDR_W'(1);
    assign go     = (state == RUN && !DbgMode)
                 || (state == STEPWAIT && Step);
    // Reset term keeps the gate low even before the state flop settles.
    assign ExecEn = go && !HaltIns && !Reset;
    assign Addr   = pc;
    assign Halted = (state == HALT);
    assign Fault  = (state == FAULT);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        push    = 1'b0;
        pop     = 1'b0;
        ack_n   = 1'b0;
        unique case (state)
            IDLE:     if (Start) state_n = RUN;
            RUN:      if (DbgMode) state_n = STEPWAIT;
            STEPWAIT: if (!DbgMode) state_n = RUN;
            HALT: begin
                if (Start) begin
                    pc_n    = pc_inc;
                    state_n = DbgMode ? STEPWAIT : RUN;
                end
            end
            FAULT:    state_n = FAULT;
            default:  state_n = IDLE;
        endcase
        if (go) begin
            ack_n = (state == STEPWAIT);
            if (Ret) begin
                if (empty) begin
                    state_n = FAULT;
                end else begin
                    pop  = 1'b1;
                    pc_n = top;
                end
            end else if (Call) begin
                if (full) begin
                    state_n = FAULT;
                end else begin
                    push = 1'b1;
                    pc_n = Target;
                end
            end else if (Jump || (BrC && CarryFlag)
                         || (BrZ && AccuZero)) begin
                pc_n = Target;
            end else if (HaltIns) begin
                state_n = HALT;
            end else begin
                pc_n = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            pc      <= '0;
            StepAck <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            StepAck <= ack_n;
        end
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench: stimulus queues per-cycle expectations, negedge monitor checks.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       DbgMode = 1'b0;
    logic       Step = 1'b0;
    logic       Jump = 1'b0;
    logic       BrC = 1'b0;
    logic       BrZ = 1'b0;
    logic       Call = 1'b0;
    logic       Ret = 1'b0;
    logic       HaltIns = 1'b0;
    logic [5:0] Target = '0;
    logic       CarryFlag = 1'b0;
    logic       AccuZero = 1'b0;
    logic [5:0] Addr;
    logic       ExecEn, Halted, Fault, StepAck;

    typedef struct {
        logic [5:0] addr;
        logic       en;
        logic       halted;
        logic       fault;
        logic       ack;
        string      name;
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;

    program_sequencer #(.ADDR_W(6), .STACK_DEPTH(4)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Start     (Start),
        .DbgMode   (DbgMode),
        .Step      (Step),
        .Jump      (Jump),
        .BrC       (BrC),
        .BrZ       (BrZ),
        .Call      (Call),
        .Ret       (Ret),
        .HaltIns   (HaltIns),
        .Target    (Target),
        .CarryFlag (CarryFlag),
        .AccuZero  (AccuZero),
        .Addr      (Addr),
        .ExecEn    (ExecEn),
        .Halted    (Halted),
        .Fault     (Fault),
        .StepAck   (StepAck)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            checks++;
            if (Addr !== me.addr || ExecEn !== me.en || Halted !== me.halted
                || Fault !== me.fault || StepAck !== me.ack) begin
                errors++;
                $display("FAIL %s: got addr=%h en=%b halted=%b fault=%b ack=%b, expected addr=%h en=%b halted=%b fault=%b ack=%b",
                         me.name, Addr, ExecEn, Halted, Fault, StepAck,
                         me.addr, me.en, me.halted, me.fault, me.ack);
            end
        end
    end

    // Queue the expected outputs for the current cycle, then advance one cycle.
    task automatic cyc(input logic [5:0] a, input logic en, input logic h,
                       input logic f, input logic k, input string nm);
        exp_t e;
        e.addr = a; e.en = en; e.halted = h; e.fault = f; e.ack = k; e.name = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        Start = 0; Step = 0; Jump = 0; BrC = 0; BrZ = 0;
        Call = 0; Ret = 0; HaltIns = 0; CarryFlag = 0; AccuZero = 0;
    endtask

    task automatic run_seq(input int from, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            cyc(6'((from + i) % 64), 1, 0, 0, 0, nm);
        end
    endtask

    task automatic do_reset();
        Reset = 1;
        cyc(0, 0, 0, 0, 0, "reset");
        Reset = 0;
    endtask

    task automatic reset_start();
        do_reset();
        Start = 1;
        cyc(0, 0, 0, 0, 0, "idle_start");
    endtask

    initial begin
        @(posedge clk);
        #1;
        // 1: free run with wrap
        do_reset();
        cyc(0, 0, 0, 0, 0, "idle_hold");
        Start = 1;
        cyc(0, 0, 0, 0, 0, "idle_start");
        run_seq(0, 70, "run_wrap");
        // 2: reset mid-run at 0x12
        run_seq(6, 12, "run_to_12");
        Reset = 1;
        cyc(0, 0, 0, 0, 0, "reset_mid");
        Reset = 0;
        cyc(0, 0, 0, 0, 0, "idle_no_start");
        cyc(0, 0, 0, 0, 0, "idle_no_start");
        // 3: return on empty stack faults
        Start = 1;
        cyc(0, 0, 0, 0, 0, "idle_start");
        Ret = 1;
        cyc(0, 1, 0, 0, 0, "ret_empty");
        Start = 1;
        cyc(0, 0, 0, 1, 0, "fault_sticky");
        cyc(0, 0, 0, 1, 0, "fault_sticky");
        // 3: call/ret, then overflow
        reset_start();
        run_seq(0, 5, "run_to_5");
        Call = 1; Target = 6'h20;
        cyc(5, 1, 0, 0, 0, "call_20");
        run_seq(6'h20, 2, "in_sub");
        Ret = 1;
        cyc(6'h22, 1, 0, 0, 0, "ret");
        Call = 1; Target = 6'h10;
        cyc(6, 1, 0, 0, 0, "call1");
        Call = 1; Target = 6'h11;
        cyc(6'h10, 1, 0, 0, 0, "call2");
        Call = 1; Target = 6'h12;
        cyc(6'h11, 1, 0, 0, 0, "call3");
        Call = 1; Target = 6'h13;
        cyc(6'h12, 1, 0, 0, 0, "call4");
        Call = 1; Target = 6'h30;
        cyc(6'h13, 1, 0, 0, 0, "call5_full");
        cyc(6'h13, 0, 0, 1, 0, "overflow_fault");
        cyc(6'h13, 0, 0, 1, 0, "overflow_fault");
        // 4: branches and strobe priority
        reset_start();
        run_seq(0, 8, "run_to_8");
        BrC = 1; CarryFlag = 0; Target = 6'h30;
        cyc(8, 1, 0, 0, 0, "brc_not_taken");
        BrC = 1; CarryFlag = 1; Target = 6'h30;
        cyc(9, 1, 0, 0, 0, "brc_taken");
        Jump = 1; BrZ = 1; Call = 1; AccuZero = 1; Target = 6'h38;
        cyc(6'h30, 1, 0, 0, 0, "triple_strobe");
        Ret = 1;
        cyc(6'h38, 1, 0, 0, 0, "ret_from_triple");
        Jump = 1; Target = 6'h3F;
        cyc(6'h31, 1, 0, 0, 0, "jump_3f");
        cyc(6'h3F, 1, 0, 0, 0, "wrap_3f");
        BrZ = 1; AccuZero = 0; Target = 6'h20;
        cyc(0, 1, 0, 0, 0, "brz_not_taken");
        Call = 1; Target = 6'h05;
        cyc(1, 1, 0, 0, 0, "call_05");
        Ret = 1; Call = 1; Target = 6'h20;
        cyc(5, 1, 0, 0, 0, "ret_beats_call");
        Ret = 1;
        cyc(2, 1, 0, 0, 0, "ret_now_empty");
        cyc(2, 0, 0, 1, 0, "no_stray_push");
        // 5: halt / resume, step ignored in halt
        reset_start();
        run_seq(0, 10, "run_to_a");
        HaltIns = 1;
        cyc(6'h0A, 0, 0, 0, 0, "halt_ins");
        for (int i = 0; i < 10; i++) begin
            Step = (i == 4);
            cyc(6'h0A, 0, 1, 0, 0, "halt_hold");
        end
        Start = 1;
        cyc(6'h0A, 0, 1, 0, 0, "halt_start");
        run_seq(6'h0B, 1, "resume");
        // 6: single step
        DbgMode = 1;
        cyc(6'h0C, 0, 0, 0, 0, "enter_dbg");
        cyc(6'h0C, 0, 0, 0, 0, "stepwait");
        for (int s = 0; s < 3; s++) begin
            Step = 1;
            cyc(6'(6'h0C + s), 1, 0, 0, 0, "step_exec");
            cyc(6'(6'h0D + s), 0, 0, 0, 1, "step_ack");
            cyc(6'(6'h0D + s), 0, 0, 0, 0, "step_idle");
            cyc(6'(6'h0D + s), 0, 0, 0, 0, "step_idle");
        end
        DbgMode = 0;
        cyc(6'h0F, 0, 0, 0, 0, "leave_dbg");
        Step = 1;
        cyc(6'h0F, 1, 0, 0, 0, "step_in_run");
        cyc(6'h10, 1, 0, 0, 0, "no_ack_in_run");
        for (int w = 0; w < 10 && sbq.size() > 0; w++) begin
            @(posedge clk);
        end
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
